// File: rtl/gp_reg_slice_pkg.sv
// Shared definitions for the gp_reg_slice chain: stage mode encoding and
// per-mode storage capacity.
package gp_reg_slice_pkg;

    typedef enum logic [1:0] {
        GP_RS_BYPASS = 2'd0,
        GP_RS_FWD    = 2'd1,
        GP_RS_BWD    = 2'd2,
        GP_RS_FULL   = 2'd3
    } gp_rs_mode_e;

    // Beats one stage can hold while downstream is stalled.
    function automatic int gp_rs_capacity(input int mode);
        case (mode)
            int'(GP_RS_FWD):  return 1;
            int'(GP_RS_BWD):  return 1;
            int'(GP_RS_FULL): return 2;
            default:          return 0;
        endcase
    endfunction

    function automatic bit gp_rs_mode_ok(input int mode);
        return (mode >= int'(GP_RS_BYPASS)) && (mode <= int'(GP_RS_FULL));
    endfunction

endpackage

// File: rtl/gp_reg_slice_stage.sv
// One valid/ready register slice; MODE selects bypass, forward, backward
// (ready cut) or full skid-buffer behaviour.
module gp_reg_slice_stage
    import gp_reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = 1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  up_valid_i,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    output logic                  up_ready_o,
    output logic                  dn_valid_o,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    input  logic                  dn_ready_i,
    output logic                  busy_o
);

    if (MODE == int'(GP_RS_BYPASS)) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ arstn_i;
        assign up_ready_o     = dn_ready_i;
        assign dn_valid_o     = up_valid_i;
        assign dn_data_o      = up_data_i;
        assign busy_o         = 1'b0;

    end else if (MODE == int'(GP_RS_FWD)) begin : g_fwd
        logic                  valid_q, valid_d;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  load;

        assign up_ready_o = dn_ready_i | ~valid_q;
        assign load       = up_ready_o & up_valid_i;
        assign valid_d    = up_ready_o ? up_valid_i : valid_q;

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) valid_q <= 1'b0;
            else          valid_q <= valid_d;
        end

        always_ff @(posedge clk_i) begin
            if (load) data_q <= up_data_i;
        end

        assign dn_valid_o = valid_q;
        assign dn_data_o  = data_q;
        assign busy_o     = valid_q;

    end else if (MODE == int'(GP_RS_BWD)) begin : g_bwd
        logic                  skid_valid_q, skid_valid_d;
        logic [DATA_WIDTH-1:0] skid_data_q;
        logic                  skid_load;

        // Upstream ready comes only from a flop, so the ready path is cut.
        assign up_ready_o   = ~skid_valid_q;
        assign skid_load    = up_valid_i & ~skid_valid_q & ~dn_ready_i;
        assign skid_valid_d = dn_ready_i ? 1'b0 : (skid_valid_q | skid_load);

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) skid_valid_q <= 1'b0;
            else          skid_valid_q <= skid_valid_d;
        end

        always_ff @(posedge clk_i) begin
            if (skid_load) skid_data_q <= up_data_i;
        end

        assign dn_valid_o = up_valid_i | skid_valid_q;
        assign dn_data_o  = skid_valid_q ? skid_data_q : up_data_i;
        assign busy_o     = skid_valid_q;

    end else if (MODE == int'(GP_RS_FULL)) begin : g_full
        logic                  out_valid_q, out_valid_d;
        logic                  skid_valid_q, skid_valid_d;
        logic [DATA_WIDTH-1:0] out_data_q, skid_data_q;
        logic                  out_load, skid_load;

        assign up_ready_o = ~skid_valid_q;
        assign out_load   = ~out_valid_q | dn_ready_i;

        always_comb begin
            out_valid_d  = out_valid_q;
            skid_valid_d = skid_valid_q;
            skid_load    = 1'b0;
            if (out_load) begin
                // Skid beat is older than anything upstream, so it goes first.
                out_valid_d  = skid_valid_q | up_valid_i;
                skid_valid_d = 1'b0;
            end else if (up_valid_i && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_load    = 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q  <= out_valid_d;
                skid_valid_q <= skid_valid_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (out_load)  out_data_q  <= skid_valid_q ? skid_data_q : up_data_i;
            if (skid_load) skid_data_q <= up_data_i;
        end

        assign dn_valid_o = out_valid_q;
        assign dn_data_o  = out_data_q;
        assign busy_o     = out_valid_q | skid_valid_q;

    end else begin : g_bad_mode
        $error("gp_reg_slice_stage: MODE=%0d is not a valid mode (0..3)", MODE);
    end

endmodule

// File: rtl/gp_reg_slice_chain.sv
// Cascade of STAGES identical register slices between an RX and a TX
// valid/ready channel; busy_o flags any stage holding a beat.
module gp_reg_slice_chain
    import gp_reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1,
    parameter int MODE       = 1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    output logic                  rx_ready_o,
    input  logic                  rx_valid_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  tx_ready_i,
    output logic                  tx_valid_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  busy_o
);

    if (STAGES < 1 || DATA_WIDTH < 1 || !gp_rs_mode_ok(MODE)) begin : g_bad_params
        $error("gp_reg_slice_chain: bad parameters DATA_WIDTH=%0d STAGES=%0d MODE=%0d",
               DATA_WIDTH, STAGES, MODE);
    end

    logic [STAGES-1:0] stage_busy;

    // Each link is owned by one generate block, so no signal loops back on itself.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic                  up_valid, up_ready, dn_valid, dn_ready;
        logic [DATA_WIDTH-1:0] up_data, dn_data;

        if (gi == 0) begin : g_head
            assign up_valid = rx_valid_i;
            assign up_data  = rx_data_i;
        end else begin : g_link
            assign up_valid = g_stage[gi-1].dn_valid;
            assign up_data  = g_stage[gi-1].dn_data;
        end

        if (gi == STAGES - 1) begin : g_tail
            assign dn_ready = tx_ready_i;
        end else begin : g_next
            assign dn_ready = g_stage[gi+1].up_ready;
        end

        gp_reg_slice_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (MODE)
        ) u_stage (
            .clk_i      (clk_i),
            .arstn_i    (arstn_i),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .up_ready_o (up_ready),
            .dn_valid_o (dn_valid),
            .dn_data_o  (dn_data),
            .dn_ready_i (dn_ready),
            .busy_o     (stage_busy[gi])
        );
    end

    assign rx_ready_o = g_stage[0].up_ready;
    assign tx_valid_o = g_stage[STAGES-1].dn_valid;
    assign tx_data_o  = g_stage[STAGES-1].dn_data;
    assign busy_o     = |stage_busy;

endmodule

// File: tb/tb_gp_reg_slice_chain.sv
// Directed bench for gp_reg_slice_chain: four instances covering FULL, FWD,
// BWD and BYPASS configurations on a shared clock and reset.
module tb_gp_reg_slice_chain;
    import gp_reg_slice_pkg::*;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // FULL, 2 stages
    logic        f2_rx_ready, f2_rx_valid, f2_tx_ready, f2_tx_valid, f2_busy;
    logic [31:0] f2_rx_data, f2_tx_data;
    // FWD, 3 stages
    logic        w3_rx_ready, w3_rx_valid, w3_tx_ready, w3_tx_valid, w3_busy;
    logic [31:0] w3_rx_data, w3_tx_data;
    // BWD, 1 stage
    logic        b1_rx_ready, b1_rx_valid, b1_tx_ready, b1_tx_valid, b1_busy;
    logic [31:0] b1_rx_data, b1_tx_data;
    // BYPASS, 4 stages
    logic        p4_rx_ready, p4_rx_valid, p4_tx_ready, p4_tx_valid, p4_busy;
    logic [31:0] p4_rx_data, p4_tx_data;

    gp_reg_slice_chain #(.DATA_WIDTH(32), .STAGES(2), .MODE(3)) u_full2 (
        .clk_i(clk), .arstn_i(rst_n),
        .rx_ready_o(f2_rx_ready), .rx_valid_i(f2_rx_valid), .rx_data_i(f2_rx_data),
        .tx_ready_i(f2_tx_ready), .tx_valid_o(f2_tx_valid), .tx_data_o(f2_tx_data),
        .busy_o(f2_busy));

    gp_reg_slice_chain #(.DATA_WIDTH(32), .STAGES(3), .MODE(1)) u_fwd3 (
        .clk_i(clk), .arstn_i(rst_n),
        .rx_ready_o(w3_rx_ready), .rx_valid_i(w3_rx_valid), .rx_data_i(w3_rx_data),
        .tx_ready_i(w3_tx_ready), .tx_valid_o(w3_tx_valid), .tx_data_o(w3_tx_data),
        .busy_o(w3_busy));

    gp_reg_slice_chain #(.DATA_WIDTH(32), .STAGES(1), .MODE(2)) u_bwd1 (
        .clk_i(clk), .arstn_i(rst_n),
        .rx_ready_o(b1_rx_ready), .rx_valid_i(b1_rx_valid), .rx_data_i(b1_rx_data),
        .tx_ready_i(b1_tx_ready), .tx_valid_o(b1_tx_valid), .tx_data_o(b1_tx_data),
        .busy_o(b1_busy));

    gp_reg_slice_chain #(.DATA_WIDTH(32), .STAGES(4), .MODE(0)) u_byp4 (
        .clk_i(clk), .arstn_i(rst_n),
        .rx_ready_o(p4_rx_ready), .rx_valid_i(p4_rx_valid), .rx_data_i(p4_rx_data),
        .tx_ready_i(p4_tx_ready), .tx_valid_o(p4_tx_valid), .tx_data_o(p4_tx_data),
        .busy_o(p4_busy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          acc, got_n, sent, rcvd, cyc;
        logic [31:0] exp_d;
        logic        r0, r1;
        logic        bv [4];
        logic [31:0] bd [4];
        logic        br [4];

        rst_n = 1'b0;
        {f2_rx_valid, f2_tx_ready, w3_rx_valid, w3_tx_ready} = '0;
        {b1_rx_valid, b1_tx_ready, p4_rx_valid, p4_tx_ready} = '0;
        f2_rx_data = '0; w3_rx_data = '0; b1_rx_data = '0; p4_rx_data = '0;

        // Reset state, FULL x2
        #2;
        chk("rst_tx_valid", 32'(f2_tx_valid), 32'd0);
        chk("rst_busy",     32'(f2_busy),     32'd0);
        chk("rst_rx_ready", 32'(f2_rx_ready), 32'd1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_tx_valid", 32'(f2_tx_valid), 32'd0);
        chk("post_rst_busy",     32'(f2_busy),     32'd0);
        chk("post_rst_rx_ready", 32'(f2_rx_ready), 32'd1);

        // Streaming, FWD x3: beat driven in cycle k appears on tx in cycle k+3
        w3_tx_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            w3_rx_valid = (k < 16);
            w3_rx_data  = 32'(k + 1);
            #1;
            if (k < 16) chk("fwd_rx_ready", 32'(w3_rx_ready), 32'd1);
            chk("fwd_tx_valid", 32'(w3_tx_valid), 32'(k >= 3 && k < 19));
            if (w3_tx_valid) begin
                $display("fwd tx beat cycle=%0d data=%h", k, w3_tx_data);
                chk("fwd_tx_data", w3_tx_data, 32'(k - 2));
            end
        end
        w3_rx_valid = 1'b0;

        // Backpressure, FULL x2: fill with tx stalled
        f2_tx_ready = 1'b0;
        acc   = 0;
        exp_d = 32'h100;
        for (int c = 0; c < 10; c++) begin
            step();
            f2_rx_valid = 1'b1;
            f2_rx_data  = exp_d;
            #1;
            if (f2_rx_ready) begin
                acc++;
                exp_d++;
            end
        end
        chk("bp_accepted",  32'(acc), 32'(2 * gp_rs_capacity(3)));
        chk("bp_rx_ready",  32'(f2_rx_ready), 32'd0);
        chk("bp_tx_valid",  32'(f2_tx_valid), 32'd1);
        chk("bp_tx_head",   f2_tx_data,       32'h100);
        chk("bp_busy",      32'(f2_busy),     32'd1);

        // Drain in order
        step();
        f2_rx_valid = 1'b0;
        f2_tx_ready = 1'b1;
        exp_d = 32'h100;
        got_n = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (f2_tx_valid) begin
                $display("drain tx beat data=%h", f2_tx_data);
                chk("drain_data", f2_tx_data, exp_d);
                exp_d++;
                got_n++;
            end
            step();
        end
        chk("drain_count",    32'(got_n),       32'd4);
        chk("drain_busy",     32'(f2_busy),     32'd0);
        chk("drain_rx_ready", 32'(f2_rx_ready), 32'd1);

        // Reset mid-stream, FULL x2: hold 3 beats then reset between edges
        f2_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f2_rx_valid = 1'b1;
            f2_rx_data  = 32'h200 + 32'(i);
            step();
        end
        f2_rx_valid = 1'b0;
        #1;
        chk("mid_held_tx_valid", 32'(f2_tx_valid), 32'd1);
        chk("mid_held_busy",     32'(f2_busy),     32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(f2_tx_valid), 32'd0);
        chk("mid_rst_busy",     32'(f2_busy),     32'd0);
        chk("mid_rst_rx_ready", 32'(f2_rx_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        f2_tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_no_stale", 32'(f2_tx_valid), 32'd0);
        end

        // Ready cut, BWD x1: random tx_ready, 1000-beat stream, glitch probe
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 1000 && cyc < 8000) begin
            step();
            b1_rx_valid = (sent < 1000);
            b1_rx_data  = 32'(sent);
            b1_tx_ready = 1'($urandom_range(0, 1));
            #1;
            r0 = b1_rx_ready;
            b1_tx_ready = ~b1_tx_ready;
            #1;
            r1 = b1_rx_ready;
            b1_tx_ready = ~b1_tx_ready;
            #1;
            chk("bwd_ready_comb", 32'(r1), 32'(r0));
            if (b1_rx_valid && b1_rx_ready) sent++;
            if (b1_tx_valid && b1_tx_ready) begin
                chk("bwd_order", b1_tx_data, 32'(rcvd));
                rcvd++;
            end
            cyc++;
        end
        b1_rx_valid = 1'b0;
        chk("bwd_received", 32'(rcvd), 32'd1000);

        // BYPASS x4: pure wires, same-cycle response
        bv[0] = 1'b1; bd[0] = 32'hDEADBEEF; br[0] = 1'b1;
        bv[1] = 1'b0; bd[1] = 32'h12345678; br[1] = 1'b0;
        bv[2] = 1'b1; bd[2] = 32'hA5A5A5A5; br[2] = 1'b0;
        bv[3] = 1'b0; bd[3] = 32'h0F0F0F0F; br[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            p4_rx_valid = bv[i];
            p4_rx_data  = bd[i];
            p4_tx_ready = br[i];
            #1;
            $display("bypass vec=%0d valid=%0b data=%h ready=%0b", i, p4_tx_valid, p4_tx_data, p4_rx_ready);
            chk("byp_tx_valid", 32'(p4_tx_valid), 32'(bv[i]));
            chk("byp_tx_data",  p4_tx_data,       bd[i]);
            chk("byp_rx_ready", 32'(p4_rx_ready), 32'(br[i]));
            chk("byp_busy",     32'(p4_busy),     32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
